interfaz_alu: RTL and testbench
===============================

Name: interfaz_alu

Overview:
UART-to-ALU sequencer that sits directly upstream of the 6-bit ALU and also consumes its result. It collects three received bytes in order: operand 1, operand 2, opcode. It drives the ALU inputs from registers, captures the combinational result, and hands it to the UART transmitter as one sign-extended byte. It is the glue between the UART rx/tx blocks and the ALU in the board-level top.

Parameters:
CANT_BITS_DATO, 8, UART byte width
CANT_BUS_ALU, 6, ALU operand/result width (must be ≤ CANT_BITS_DATO)
CANT_BITS_OPCODE, 4, ALU opcode width

Ports:
i_clock  in  1  system clock, all logic on rising edge
i_reset  in  1  asynchronous, active-low reset
i_rx_data  in  CANT_BITS_DATO  byte from UART receiver, valid when i_rx_done=1
i_rx_done  in  1  one-cycle pulse, new byte available
i_tx_done  in  1  one-cycle pulse, transmitter finished current byte
i_resultado  in  CANT_BUS_ALU  signed result from ALU (combinational)
o_operando_1  out  CANT_BUS_ALU  registered operand 1 to ALU
o_operando_2  out  CANT_BUS_ALU  registered operand 2 to ALU
o_opcode  out  CANT_BITS_OPCODE  registered opcode to ALU
o_tx_data  out  CANT_BITS_DATO  byte to transmit
o_tx_start  out  1  one-cycle pulse requesting transmission
o_busy  out  1  high while a result is being produced or sent
o_overrun  out  1  sticky flag, received byte was dropped

Behaviour:
- Reset (i_reset=0, asynchronous): state ESPERA_OP1. o_operando_1, o_operando_2, o_opcode, o_tx_data = 0. o_tx_start, o_busy, o_overrun = 0. Reset mid-operation aborts any partial frame or pending transmit; no o_tx_start is issued.
- FSM, Moore outputs, one transition per clock:
  - ESPERA_OP1: on i_rx_done, o_operando_1 <= i_rx_data[CANT_BUS_ALU-1:0]; go to ESPERA_OP2.
  - ESPERA_OP2: on i_rx_done, o_operando_2 <= low CANT_BUS_ALU bits; go to ESPERA_OPCODE.
  - ESPERA_OPCODE: on i_rx_done, o_opcode <= i_rx_data[CANT_BITS_OPCODE-1:0]; go to CALCULO.
  - CALCULO (exactly 1 cycle): o_tx_data <= sign-extension of i_resultado to CANT_BITS_DATO; go to ENVIO.
  - ENVIO (exactly 1 cycle): o_tx_start=1; go to ESPERA_TX.
  - ESPERA_TX: on i_tx_done, go to ESPERA_OP1.
- Latency: if the opcode byte's i_rx_done is high in cycle k, CALCULO is cycle k+1 and o_tx_start is high in cycle k+2 only.
- o_busy = 1 in CALCULO, ENVIO and ESPERA_TX; 0 otherwise.
- Upper received bits beyond the operand/opcode width are discarded silently. This is truncation, not an error.
- ALU inputs hold their last values between frames. o_tx_data holds until the next CALCULO.
- Boundary conditions:
  - i_rx_done while o_busy=1: byte dropped, o_overrun <= 1. This includes i_rx_done coincident with i_tx_done in ESPERA_TX; the FSM still returns to ESPERA_OP1.
  - i_tx_done outside ESPERA_TX: ignored.
  - o_overrun clears only on reset.
  - Back-to-back frames: the first byte can be accepted in the cycle after ESPERA_TX exits.
- No combinational path from any input to any output.

Decomposition:
- Shared header: width constants (CANT_BITS_DATO, CANT_BUS_ALU, CANT_BITS_OPCODE) and the six state encodings (3-bit, binary). The same header is included by the top and the testbench.
- No sub-module. Sign extension and operand capture are inline. The ALU is instantiated beside this block in the top level, not inside it.

Test Plan:
1. Release reset, then rx 0x05, 0x03, 0x08 (ADD) -> o_operando_1=5, o_operando_2=3, o_opcode=8; o_tx_data=0x08; o_tx_start pulses exactly 2 cycles after the third i_rx_done.
2. Rx 0x03, 0x05, 0x0A (SUB) -> ALU gives 6'h3E (-2); o_tx_data=0xFE (sign-extended).
3. Rx 0xE0 (truncated to 6'h20 = -32), 0x02, 0x03 (SRA) -> o_tx_data=0xF8 (-8); o_overrun stays 0.
4. Complete a frame, then pulse i_rx_done with 0x11 in ESPERA_TX before i_tx_done -> byte dropped, o_overrun=1, o_operando_1 unchanged. After i_tx_done, the next frame is processed normally and o_overrun stays 1.
5. Rx two bytes, then assert i_reset low -> all outputs 0, state ESPERA_OP1. Then rx 0x01, 0x01, 0x0D (OR) -> o_tx_data=0x01; the aborted bytes are not reused.
6. Pulse i_tx_done in ESPERA_OP1 and i_rx_done in the same cycle as i_tx_done in ESPERA_TX -> stray tx_done ignored; coincident case returns to ESPERA_OP1 and sets o_overrun.

Source files
------------

// File: rtl/interfaz_alu_pkg.sv
// Shared widths and sequencer state encoding for the UART-to-ALU glue and its bench.
package interfaz_alu_pkg;

  localparam int DEF_BITS_DATO   = 8;
  localparam int DEF_BUS_ALU     = 6;
  localparam int DEF_BITS_OPCODE = 4;

  typedef enum logic [2:0] {
    ESPERA_OP1    = 3'd0,
    ESPERA_OP2    = 3'd1,
    ESPERA_OPCODE = 3'd2,
    CALCULO       = 3'd3,
    ENVIO         = 3'd4,
    ESPERA_TX     = 3'd5
  } estado_t;

endpackage

// File: rtl/interfaz_alu.sv
// Collects op1/op2/opcode bytes from UART rx, drives the ALU, and sends its sign-extended result.
// o_tx_start pulses two cycles after the opcode byte; bytes arriving while busy are dropped (sticky overrun).
module interfaz_alu
  import interfaz_alu_pkg::*;
#(
  parameter int CANT_BITS_DATO   = DEF_BITS_DATO,
  parameter int CANT_BUS_ALU     = DEF_BUS_ALU,
  parameter int CANT_BITS_OPCODE = DEF_BITS_OPCODE
) (
  input  logic                        i_clock,
  input  logic                        i_reset,
  input  logic [CANT_BITS_DATO-1:0]   i_rx_data,
  input  logic                        i_rx_done,
  input  logic                        i_tx_done,
  input  logic [CANT_BUS_ALU-1:0]     i_resultado,
  output logic [CANT_BUS_ALU-1:0]     o_operando_1,
  output logic [CANT_BUS_ALU-1:0]     o_operando_2,
  output logic [CANT_BITS_OPCODE-1:0] o_opcode,
  output logic [CANT_BITS_DATO-1:0]   o_tx_data,
  output logic                        o_tx_start,
  output logic                        o_busy,
  output logic                        o_overrun
);

  estado_t estado, estado_nxt;
  logic    busy;
  logic    unused_rx_bits;

  // Upper received bits are truncated by design.
  assign unused_rx_bits = ^i_rx_data;

  assign busy       = (estado == CALCULO) || (estado == ENVIO) || (estado == ESPERA_TX);
  assign o_busy     = busy;
  assign o_tx_start = (estado == ENVIO);

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) estado <= ESPERA_OP1;
    else          estado <= estado_nxt;
  end

  always_comb begin
    estado_nxt = estado;
    case (estado)
      ESPERA_OP1:    if (i_rx_done) estado_nxt = ESPERA_OP2;
      ESPERA_OP2:    if (i_rx_done) estado_nxt = ESPERA_OPCODE;
      ESPERA_OPCODE: if (i_rx_done) estado_nxt = CALCULO;
      CALCULO:       estado_nxt = ENVIO;
      ENVIO:         estado_nxt = ESPERA_TX;
      ESPERA_TX:     if (i_tx_done) estado_nxt = ESPERA_OP1;
      default:       estado_nxt = ESPERA_OP1;
    endcase
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      o_operando_1 <= '0;
      o_operando_2 <= '0;
      o_opcode     <= '0;
      o_tx_data    <= '0;
      o_overrun    <= 1'b0;
    end else begin
      if (i_rx_done && busy) o_overrun <= 1'b1;
      case (estado)
        ESPERA_OP1:    if (i_rx_done) o_operando_1 <= i_rx_data[CANT_BUS_ALU-1:0];
        ESPERA_OP2:    if (i_rx_done) o_operando_2 <= i_rx_data[CANT_BUS_ALU-1:0];
        ESPERA_OPCODE: if (i_rx_done) o_opcode <= i_rx_data[CANT_BITS_OPCODE-1:0];
        // ALU result is combinational from the registered operands; sample it once they settle.
        CALCULO:       o_tx_data <= CANT_BITS_DATO'($signed(i_resultado));
        default:       ;
      endcase
    end
  end

endmodule

// File: tb/tb_interfaz_alu.sv
// Scoreboarded bench for interfaz_alu with a behavioural ALU beside the DUT.
module tb_interfaz_alu;
  import interfaz_alu_pkg::*;

  localparam int DW = DEF_BITS_DATO;
  localparam int AW = DEF_BUS_ALU;
  localparam int OW = DEF_BITS_OPCODE;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [DW-1:0] rx_data = '0;
  logic          rx_done = 1'b0;
  logic          tx_done = 1'b0;
  logic [AW-1:0] resultado;
  logic [AW-1:0] op1, op2;
  logic [OW-1:0] opcode;
  logic [DW-1:0] tx_data;
  logic          tx_start, busy, overrun;

  int cyc = 0;
  int last_rx_cyc = 0;
  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [DW-1:0] tx;
    logic [AW-1:0] a;
    logic [AW-1:0] b;
    logic [OW-1:0] op;
    int            when;
  } exp_t;
  exp_t sb[$];

  interfaz_alu dut (
    .i_clock      (clk),
    .i_reset      (rst_n),
    .i_rx_data    (rx_data),
    .i_rx_done    (rx_done),
    .i_tx_done    (tx_done),
    .i_resultado  (resultado),
    .o_operando_1 (op1),
    .o_operando_2 (op2),
    .o_opcode     (opcode),
    .o_tx_data    (tx_data),
    .o_tx_start   (tx_start),
    .o_busy       (busy),
    .o_overrun    (overrun)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Board-level ALU stand-in.
  always_comb begin
    case (opcode)
      4'h8:    resultado = op1 + op2;
      4'hA:    resultado = op1 - op2;
      4'hC:    resultado = op1 & op2;
      4'hD:    resultado = op1 | op2;
      4'hE:    resultado = op1 ^ op2;
      4'h3:    resultado = $signed(op1) >>> op2;
      4'h2:    resultado = op1 >> op2;
      4'hF:    resultado = ~(op1 | op2);
      default: resultado = '0;
    endcase
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && tx_start) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_tx_start: got pulse at cycle %0d expected none", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("tx_data", 32'(tx_data), 32'(e.tx));
        check("operando_1", 32'(op1), 32'(e.a));
        check("operando_2", 32'(op2), 32'(e.b));
        check("opcode", 32'(opcode), 32'(e.op));
        check("tx_start_cycle", 32'(cyc), 32'(e.when));
      end
    end
  end

  // Called at a negedge; returns one negedge later.
  task automatic send_byte(input logic [DW-1:0] b);
    rx_data     = b;
    rx_done     = 1'b1;
    last_rx_cyc = cyc;
    @(negedge clk);
    rx_done = 1'b0;
  endtask

  task automatic frame(input logic [DW-1:0] a, input logic [DW-1:0] b,
                       input logic [DW-1:0] op, input logic [DW-1:0] exp_tx);
    exp_t e;
    bit   seen;
    send_byte(a);
    send_byte(b);
    send_byte(op);
    e.tx = exp_tx; e.a = a[AW-1:0]; e.b = b[AW-1:0]; e.op = op[OW-1:0];
    e.when = last_rx_cyc + 2;
    sb.push_back(e);
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (tx_start) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL tx_start_timeout: got no pulse expected one after opcode at cycle %0d", last_rx_cyc);
    end
  endtask

  task automatic tx_ack();
    repeat (2) @(negedge clk);
    tx_done = 1'b1;
    @(negedge clk);
    tx_done = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge clk);
    check("rst_operando_1", 32'(op1), 32'h0);
    check("rst_tx_data", 32'(tx_data), 32'h0);
    check("rst_flags", {29'b0, tx_start, busy, overrun}, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // 1: ADD 5+3
    frame(8'h05, 8'h03, 8'h08, 8'h08);
    check("busy_in_envio", 32'(busy), 32'h1);
    tx_ack();
    check("idle_after_tx", 32'(busy), 32'h0);

    // 2: SUB 3-5 = -2
    frame(8'h03, 8'h05, 8'h0A, 8'hFE);
    tx_ack();

    // 3: SRA of truncated -32 by 2
    frame(8'hE0, 8'h02, 8'h03, 8'hF8);
    tx_ack();
    check("no_overrun_on_trunc", 32'(overrun), 32'h0);

    // 4: byte during ESPERA_TX is dropped
    frame(8'h2A, 8'h15, 8'h0E, 8'hFF);
    @(negedge clk);
    send_byte(8'h11);
    check("overrun_set", 32'(overrun), 32'h1);
    check("op1_kept", 32'(op1), 32'h2A);
    check("busy_in_tx_wait", 32'(busy), 32'h1);
    tx_ack();
    frame(8'h3F, 8'h01, 8'h08, 8'h00);
    tx_ack();
    check("overrun_sticky", 32'(overrun), 32'h1);

    // 5: reset aborts a partial frame
    send_byte(8'h07);
    send_byte(8'h09);
    #2 rst_n = 1'b0;
    #1;
    check("abort_operandos", {20'b0, op1, op2}, 32'h0);
    check("abort_opcode_tx", {20'b0, opcode, tx_data}, 32'h0);
    check("abort_flags", {29'b0, tx_start, busy, overrun}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    frame(8'h01, 8'h01, 8'h0D, 8'h01);
    tx_ack();

    // 6: stray tx_done while idle, then rx/tx coincident in ESPERA_TX
    tx_done = 1'b1;
    @(negedge clk);
    tx_done = 1'b0;
    check("stray_tx_done_idle", {30'b0, busy, tx_start}, 32'h0);
    frame(8'h10, 8'h03, 8'h02, 8'h02);
    @(negedge clk);
    check("overrun_before_coinc", 32'(overrun), 32'h0);
    rx_data = 8'h2A;
    rx_done = 1'b1;
    tx_done = 1'b1;
    @(negedge clk);
    rx_done = 1'b0;
    tx_done = 1'b0;
    check("coinc_idle", 32'(busy), 32'h0);
    check("coinc_overrun", 32'(overrun), 32'h1);
    check("coinc_op1_kept", 32'(op1), 32'h10);
    frame(8'h20, 8'h01, 8'h0F, 8'h1E);
    tx_ack();

    repeat (4) @(negedge clk);
    check("scoreboard_drained", 32'(sb.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
